bcd_scan_display: RTL and testbench
===================================

# bcd_scan_display

Four-digit time-multiplexed seven-segment driver that sits directly downstream of the decade counters. It takes four packed BCD digits from a cascaded decade-counter chain and scans them onto a common-anode four-digit display, one digit per scan slot. It also provides leading-zero blanking, decimal points, and a visible error glyph for non-BCD codes. Digits are snapshotted once per frame so a counter rolling over mid-scan never produces a torn display.

## Interface
- SCAN_DIV, default 1000: clock cycles per digit slot; legal range ≥ 2. The prescaler width is ceil(log2(SCAN_DIV)).
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  scan enable; when low, the prescaler and digit index hold.
- digits  in  16  packed BCD: [3:0] = digit 0 (least significant), [15:12] = digit 3.
- dp_mask  in  4  decimal-point request per digit; bit i belongs to digit i.
- blank_lz  in  1  leading-zero blanking enable.
- an  out  4  anode selects, active-low; bit i drives digit i.
- seg  out  7  segments, active-high; seg[0]=a … seg[6]=g.
- dp  out  1  decimal point, active-high.
- err  out  1  high while the displayed digit is a non-BCD code.

## Operation
- **Prescaler.** pc counts 0..SCAN_DIV-1 while en=1. A tick occurs when pc==SCAN_DIV-1 and en=1; on that edge pc returns to 0. When en=0, pc holds.
- **Digit index.** idx is a 2-bit register that increments on each tick and wraps from 3 to 0.
- **Frame snapshot.** On the tick edge where idx goes 3→0, digits and dp_mask are loaded into shadow registers.
  - The slot-0 outputs on that same edge use the newly loaded values.
  - Input changes at any other time are ignored until the next frame start.
- **Decode for 0–9:** 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F.
- **Decode for 10–15:** dash 40, with err=1 for that slot.
- **Leading-zero blanking** (blank_lz=1):
  - Scanning from digit 3 down, each shadow digit equal to 0 is blanked until the first non-zero digit.
  - Digit 0 is never blanked.
  - For a blanked slot: an=1111, seg=0, dp=0, err=0.
  - Invalid codes count as non-zero.
  - blank_lz is evaluated combinationally against the shadow registers at each tick.
- **Active slot outputs:**
  - an = all ones except bit idx, which is 0.
  - seg = decode of shadow digit idx.
  - dp = shadow dp_mask[idx].
- **Reset values** (rst low, asynchronous): pc=0, idx=3, shadow digits=0, shadow dp_mask=0, an=1111, seg=0000000, dp=0, err=0. Setting idx=3 makes the first tick after reset begin a frame at digit 0.
- **Reset mid-frame:** outputs go to their reset values immediately, with no clock required. The scan restarts as if from power-up.

## Timing
- an, seg, dp and err are registered and change only on a tick edge (or on async reset). They change on the same edge as idx; there is no extra pipeline delay.
- The first tick after reset release occurs on the SCAN_DIV-th rising edge with en=1. Outputs stay dark (an=1111) until that edge.
- Each slot lasts SCAN_DIV enabled cycles; one frame is 4×SCAN_DIV enabled cycles.
- Digit-change latency, from a change on digits to the display showing it: at most 4×SCAN_DIV plus the length of the current partial slot.
- **en deasserted:** the current slot's outputs stay driven and unchanged. When en returns, counting resumes from the held pc value; no count is lost and none is repeated.
- **en low on the would-be tick cycle:** no tick occurs that cycle.
- **Simultaneous frame-start tick and digits change:** the value present at that edge is the one captured.

## Test plan
With SCAN_DIV=4:
1. **Reset.** Assert rst low mid-slot → an=1111, seg=0, dp=0, err=0 immediately. Release with digits=16'h0000 and blank_lz=0 → on the 4th rising edge: an=1110, seg=3F.
2. **Basic scan.** digits=16'h2705, dp_mask=0010 → slot 0: an=1110, seg=6D; slot 1: an=1101, seg=3F, dp=1; slot 2: an=1011, seg=07; slot 3: an=0111, seg=5B; then back to slot 0. Each slot lasts exactly 4 cycles.
3. **Leading-zero blanking.** blank_lz=1, digits=16'h0040 → slots 3 and 2: an=1111, seg=0; slot 1: seg=66; slot 0: seg=3F. With digits=16'h0000, only slot 0 lights (seg=3F).
4. **Invalid digit.** digits=16'h00A0 → slot 1: seg=40, err=1. All other slots: err=0.
5. **Snapshot.** Change digits from 16'h1111 to 16'h9999 during slot 2 → slots 2–3 still show 06. The next slot 0 shows 6F.
6. **Enable hold.** Hold en low for 10 cycles during slot 2 → an=1011 for 14 cycles total. The slot-3 tick then follows after the remaining prescaler count; the held pc value is preserved.

Source files
------------

// File: rtl/bcd_scan_display.sv
// ---------------------------------------------------------------------------
// bcd_scan_display
// Four-digit time-multiplexed seven-segment driver for a common-anode display.
// A prescaler divides clk into scan slots. Each slot lights one digit from a
// shadow copy of the BCD input. The shadow copy is refreshed once per frame,
// so a counter that rolls over mid-scan never shows a torn value. Leading-zero
// blanking, per-digit decimal points and a dash glyph with an error flag for
// non-BCD codes are included. All display outputs are registered and change
// only on a tick edge or on asynchronous reset.
// ---------------------------------------------------------------------------
module bcd_scan_display #(
    parameter int SCAN_DIV = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_mask,
    input  logic        blank_lz,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        err
);

    // Prescaler width. A SCAN_DIV of 2 still needs one bit.
    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PC_LAST = PW'(SCAN_DIV - 1);

    // Seven-segment pattern (seg[0]=a .. seg[6]=g). Any non-BCD code shows a dash.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    // True when the nibble is a legal BCD digit (0..9).
    function automatic logic is_bcd(input logic [3:0] d);
        return (d <= 4'd9);
    endfunction

    // Prescaler and scan position
    logic [PW-1:0] pc_r;
    logic [PW-1:0] pc_nxt_s;
    logic          tick_s;
    logic [1:0]    idx_r;
    logic [1:0]    idx_nxt_s;
    logic          frame_start_s;

    // Frame snapshot
    logic [15:0]   shadow_dig_r;
    logic [3:0]    shadow_dp_r;
    logic [15:0]   cur_dig_s;
    logic [3:0]    cur_dp_s;

    // Slot decode
    logic [3:0]    blank_s;
    logic [3:0]    sel_dig_s;
    logic          sel_dp_s;
    logic          sel_blank_s;
    logic [3:0]    sel_an_s;

    // Registered outputs and their next values
    logic [3:0]    an_r;
    logic [6:0]    seg_r;
    logic          dp_r;
    logic          err_r;
    logic [3:0]    an_nxt_s;
    logic [6:0]    seg_nxt_s;
    logic          dp_nxt_s;
    logic          err_nxt_s;

    // The tick fires on the last prescaler count, and only while scanning is enabled.
    assign tick_s        = en && (pc_r == PC_LAST);
    // A frame begins when the index wraps from slot 3 back to slot 0.
    assign frame_start_s = tick_s && (idx_r == 2'd3);

    // Next prescaler count: hold while disabled, and wrap to zero on the tick.
    always_comb begin
        pc_nxt_s = pc_r;
        if (!en) begin
            pc_nxt_s = pc_r;
        end else if (pc_r == PC_LAST) begin
            pc_nxt_s = '0;
        end else begin
            pc_nxt_s = pc_r + {{(PW-1){1'b0}}, 1'b1};
        end
    end

    // Next digit index: advance once per tick and wrap naturally from 3 to 0.
    always_comb begin
        idx_nxt_s = idx_r;
        if (tick_s) begin
            idx_nxt_s = idx_r + 2'd1;
        end else begin
            idx_nxt_s = idx_r;
        end
    end

    // On the frame-start edge, slot 0 must already use the freshly sampled inputs.
    always_comb begin
        cur_dig_s = shadow_dig_r;
        cur_dp_s  = shadow_dp_r;
        if (frame_start_s) begin
            cur_dig_s = digits;
            cur_dp_s  = dp_mask;
        end else begin
            cur_dig_s = shadow_dig_r;
            cur_dp_s  = shadow_dp_r;
        end
    end

    // Leading-zero mask. Zeros are blanked from digit 3 downwards until the
    // first non-zero digit. Invalid codes count as non-zero, and digit 0 always shows.
    always_comb begin
        blank_s = 4'b0000;
        if (blank_lz) begin
            blank_s[3] = (cur_dig_s[15:12] == 4'd0);
            blank_s[2] = blank_s[3] && (cur_dig_s[11:8] == 4'd0);
            blank_s[1] = blank_s[2] && (cur_dig_s[7:4]  == 4'd0);
            blank_s[0] = 1'b0;
        end else begin
            blank_s = 4'b0000;
        end
    end

    // Select the digit, decimal point, blank flag and anode pattern of the slot being entered.
    always_comb begin
        sel_dig_s   = cur_dig_s[3:0];
        sel_dp_s    = cur_dp_s[0];
        sel_blank_s = blank_s[0];
        sel_an_s    = 4'b1110;
        case (idx_nxt_s)
            2'd0: begin
                sel_dig_s   = cur_dig_s[3:0];
                sel_dp_s    = cur_dp_s[0];
                sel_blank_s = blank_s[0];
                sel_an_s    = 4'b1110;
            end
            2'd1: begin
                sel_dig_s   = cur_dig_s[7:4];
                sel_dp_s    = cur_dp_s[1];
                sel_blank_s = blank_s[1];
                sel_an_s    = 4'b1101;
            end
            2'd2: begin
                sel_dig_s   = cur_dig_s[11:8];
                sel_dp_s    = cur_dp_s[2];
                sel_blank_s = blank_s[2];
                sel_an_s    = 4'b1011;
            end
            2'd3: begin
                sel_dig_s   = cur_dig_s[15:12];
                sel_dp_s    = cur_dp_s[3];
                sel_blank_s = blank_s[3];
                sel_an_s    = 4'b0111;
            end
            default: begin
                sel_dig_s   = cur_dig_s[3:0];
                sel_dp_s    = 1'b0;
                sel_blank_s = 1'b1;
                sel_an_s    = 4'b1111;
            end
        endcase
    end

    // Output values for the slot being entered. A blanked slot is fully dark and clean.
    always_comb begin
        an_nxt_s  = 4'b1111;
        seg_nxt_s = 7'h00;
        dp_nxt_s  = 1'b0;
        err_nxt_s = 1'b0;
        if (sel_blank_s) begin
            an_nxt_s  = 4'b1111;
            seg_nxt_s = 7'h00;
            dp_nxt_s  = 1'b0;
            err_nxt_s = 1'b0;
        end else begin
            an_nxt_s  = sel_an_s;
            seg_nxt_s = seg_decode(sel_dig_s);
            dp_nxt_s  = sel_dp_s;
            err_nxt_s = !is_bcd(sel_dig_s);
        end
    end

    // Prescaler and digit index. Reset parks the index at 3, so the first tick starts a frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_r  <= '0;
            idx_r <= 2'd3;
        end else begin
            pc_r  <= pc_nxt_s;
            idx_r <= idx_nxt_s;
        end
    end

    // Frame snapshot of the digits and decimal points, taken only at a frame start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_dig_r <= 16'h0000;
            shadow_dp_r  <= 4'b0000;
        end else if (frame_start_s) begin
            shadow_dig_r <= digits;
            shadow_dp_r  <= dp_mask;
        end
    end

    // Display outputs. They update on the same edge as the index and are dark out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an_r  <= 4'b1111;
            seg_r <= 7'h00;
            dp_r  <= 1'b0;
            err_r <= 1'b0;
        end else if (tick_s) begin
            an_r  <= an_nxt_s;
            seg_r <= seg_nxt_s;
            dp_r  <= dp_nxt_s;
            err_r <= err_nxt_s;
        end
    end

    assign an  = an_r;
    assign seg = seg_r;
    assign dp  = dp_r;
    assign err = err_r;

endmodule

// File: tb/tb_bcd_scan_display.sv
// ---------------------------------------------------------------------------
// tb_bcd_scan_display
// Directed test of bcd_scan_display with SCAN_DIV=4. After every rising edge,
// the stimulus process queues the output values it expects, which are worked
// out by hand. A separate monitor pops one entry on each falling edge and
// compares it with the DUT outputs. Checks of the asynchronous reset happen
// immediately, with no clock edge in between.
// ---------------------------------------------------------------------------
module tb_bcd_scan_display;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] digits;
    logic [3:0]  dp_mask;
    logic        blank_lz;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        err;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    int   mon_n = 0;

    bcd_scan_display #(.SCAN_DIV(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .digits   (digits),
        .dp_mask  (dp_mask),
        .blank_lz (blank_lz),
        .an       (an),
        .seg      (seg),
        .dp       (dp),
        .err      (err)
    );

    // 10-unit clock period.
    always #5 clk = ~clk;

    // Monitor: on each falling edge, compare the DUT outputs with the oldest queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            mon_n = mon_n + 1;
            total = total + 1;
            if ({an, seg, dp, err} !== mon_e) begin
                bad = bad + 1;
                $display("FAIL scan_cycle%0d: got an=%b seg=%h dp=%b err=%b, want an=%b seg=%h dp=%b err=%b",
                         mon_n, an, seg, dp, err, mon_e.an, mon_e.seg, mon_e.dp, mon_e.err);
            end
        end
    end

    // Wait n rising edges. After each one, queue the given expected outputs.
    task automatic expect_cycles(input logic [3:0] a, input logic [6:0] s,
                                 input logic d, input logic e, input int n);
        exp_t t;
        t.an  = a;
        t.seg = s;
        t.dp  = d;
        t.err = e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            exp_q.push_back(t);
        end
    endtask

    // Check immediately that the outputs hold their reset values.
    task automatic check_dark(input string name);
        total = total + 1;
        if (an !== 4'b1111 || seg !== 7'h00 || dp !== 1'b0 || err !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL %s: got an=%b seg=%h dp=%b err=%b, want an=1111 seg=00 dp=0 err=0",
                     name, an, seg, dp, err);
        end
    endtask

    initial begin
        rst      = 1'b0;
        en       = 1'b1;
        digits   = 16'h0000;
        dp_mask  = 4'b0000;
        blank_lz = 1'b0;

        // Power-up reset, then release. The 4th edge after release lights digit 0.
        repeat (2) @(posedge clk);
        #1;
        check_dark("reset_initial");
        rst = 1'b1;
        expect_cycles(4'b1111, 7'h00, 1'b0, 1'b0, 3);
        expect_cycles(4'b1110, 7'h3F, 1'b0, 1'b0, 4);
        digits  = 16'h2705;                         // mid-frame: ignored until the next frame
        dp_mask = 4'b0010;
        expect_cycles(4'b1101, 7'h3F, 1'b0, 1'b0, 4);
        expect_cycles(4'b1011, 7'h3F, 1'b0, 1'b0, 4);
        expect_cycles(4'b0111, 7'h3F, 1'b0, 1'b0, 4);

        // Basic scan of 2705 with the decimal point on digit 1.
        expect_cycles(4'b1110, 7'h6D, 1'b0, 1'b0, 4);
        expect_cycles(4'b1101, 7'h3F, 1'b1, 1'b0, 4);
        expect_cycles(4'b1011, 7'h07, 1'b0, 1'b0, 4);
        expect_cycles(4'b0111, 7'h5B, 1'b0, 1'b0, 4);
        expect_cycles(4'b1110, 7'h6D, 1'b0, 1'b0, 4);
        blank_lz = 1'b1;                            // 2705 has no leading zeros
        digits   = 16'h0040;
        expect_cycles(4'b1101, 7'h3F, 1'b1, 1'b0, 4);
        expect_cycles(4'b1011, 7'h07, 1'b0, 1'b0, 4);
        expect_cycles(4'b0111, 7'h5B, 1'b0, 1'b0, 4);

        // Leading-zero blanking of 0040: slots 2 and 3 are dark.
        expect_cycles(4'b1110, 7'h3F, 1'b0, 1'b0, 4);
        digits = 16'h0000;
        expect_cycles(4'b1101, 7'h66, 1'b1, 1'b0, 4);
        expect_cycles(4'b1111, 7'h00, 1'b0, 1'b0, 4);
        expect_cycles(4'b1111, 7'h00, 1'b0, 1'b0, 4);

        // All zeros: only digit 0 lights, and the blanked digit 1 drops its decimal point.
        expect_cycles(4'b1110, 7'h3F, 1'b0, 1'b0, 4);
        digits  = 16'h00A0;
        dp_mask = 4'b1111;
        expect_cycles(4'b1111, 7'h00, 1'b0, 1'b0, 12);

        // Invalid code A in digit 1 counts as non-zero and shows a dash with err.
        expect_cycles(4'b1110, 7'h3F, 1'b1, 1'b0, 4);
        blank_lz = 1'b0;                            // re-evaluated at the next ticks
        digits   = 16'h1111;
        dp_mask  = 4'b0000;
        expect_cycles(4'b1101, 7'h40, 1'b1, 1'b1, 4);
        expect_cycles(4'b1011, 7'h3F, 1'b1, 1'b0, 4);
        expect_cycles(4'b0111, 7'h3F, 1'b1, 1'b0, 4);

        // Snapshot: a change during slot 2 does not reach the display until the next frame.
        expect_cycles(4'b1110, 7'h06, 1'b0, 1'b0, 4);
        expect_cycles(4'b1101, 7'h06, 1'b0, 1'b0, 4);
        expect_cycles(4'b1011, 7'h06, 1'b0, 1'b0, 1);
        digits = 16'h9999;
        expect_cycles(4'b1011, 7'h06, 1'b0, 1'b0, 3);
        expect_cycles(4'b0111, 7'h06, 1'b0, 1'b0, 4);
        expect_cycles(4'b1110, 7'h6F, 1'b0, 1'b0, 4);
        expect_cycles(4'b1101, 7'h6F, 1'b0, 1'b0, 4);

        // Enable hold in slot 2: 2 + 10 held + 2 = 14 cycles on an=1011.
        expect_cycles(4'b1011, 7'h6F, 1'b0, 1'b0, 2);
        en = 1'b0;
        expect_cycles(4'b1011, 7'h6F, 1'b0, 1'b0, 10);
        en = 1'b1;
        expect_cycles(4'b1011, 7'h6F, 1'b0, 1'b0, 2);
        expect_cycles(4'b0111, 7'h6F, 1'b0, 1'b0, 4);
        expect_cycles(4'b1110, 7'h6F, 1'b0, 1'b0, 2);

        // Reset asserted mid-slot, away from any clock edge, darkens the outputs immediately.
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_dark("reset_midslot");
        expect_cycles(4'b1111, 7'h00, 1'b0, 1'b0, 2);
        rst     = 1'b1;
        digits  = 16'h0000;
        dp_mask = 4'b0000;
        expect_cycles(4'b1111, 7'h00, 1'b0, 1'b0, 3);
        expect_cycles(4'b1110, 7'h3F, 1'b0, 1'b0, 4);
        expect_cycles(4'b1101, 7'h3F, 1'b0, 1'b0, 4);

        // Let the monitor drain the queue, with a bounded wait.
        for (int i = 0; i < 4; i++) begin
            if (exp_q.size() != 0) begin
                @(negedge clk);
                #1;
            end
        end
        total = total + 1;
        if (exp_q.size() != 0) begin
            bad = bad + 1;
            $display("FAIL queue_drain: got %0d entries left, want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
